// File: rtl/vga_timing_sequencer.sv
// 640x480 VGA timing generator: pixel-rate enable, h/v counters, active-low syncs,
// blanking, and a frame-latched colour select driving 4-bit RGB.
module vga_timing_sequencer #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned H_VISIBLE    = 640,
    parameter int unsigned H_SYNC_START = 659,
    parameter int unsigned H_SYNC_END   = 755,
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned V_VISIBLE    = 480,
    parameter int unsigned V_SYNC_START = 493,
    parameter int unsigned V_SYNC_END   = 494,
    parameter int unsigned V_TOTAL      = 525
) (
    input  logic       clk_100Mhz,
    input  logic       reset,
    input  logic [7:0] sw,
    output logic       Hsync,
    output logic       Vsync,
    output logic [3:0] vgaRed,
    output logic [3:0] vgaGreen,
    output logic [3:0] vgaBlue,
    output logic       pixel_tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       frame_start
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_S = 10'(H_SYNC_START);
    localparam logic [9:0] H_SYNC_E = 10'(H_SYNC_END);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_S = 10'(V_SYNC_START);
    localparam logic [9:0] V_SYNC_E = 10'(V_SYNC_END);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hcount;
    logic [9:0]       r_vcount;
    logic [7:0]       r_cfg;
    logic             r_hsync;
    logic             r_vsync;
    logic [11:0]      r_rgb;
    logic             r_pixel_tick;
    logic             r_frame_start;

    logic             w_tick_now;
    logic             w_frame_end;
    logic [DIV_W-1:0] w_div_next;
    logic [9:0]       w_hcount_next;
    logic [9:0]       w_vcount_next;
    logic [7:0]       w_cfg_next;
    logic             w_video_on;
    logic [11:0]      w_colour;

    assign w_tick_now  = (r_div == DIV_LAST);
    assign w_frame_end = w_tick_now && (r_hcount == H_LAST) && (r_vcount == V_LAST);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_div_next    = w_tick_now ? '0 : r_div + 1'b1;
        w_hcount_next = r_hcount;
        w_vcount_next = r_vcount;
        w_cfg_next    = r_cfg;
        if (w_tick_now) begin
            if (r_hcount == H_LAST) begin
                w_hcount_next = '0;
                if (r_vcount == V_LAST) begin
                    w_vcount_next = '0;
                    w_cfg_next    = sw;
                end else begin
                    w_vcount_next = r_vcount + 10'd1;
                end
            end else begin
                w_hcount_next = r_hcount + 10'd1;
            end
        end
    end

    // Highest set bit of the latched switch value selects the colour.
    always_comb begin
        w_colour = 12'h000;
        if      (w_cfg_next[7]) w_colour = 12'hFFF;
        else if (w_cfg_next[6]) w_colour = 12'hFF0;
        else if (w_cfg_next[5]) w_colour = 12'hF0F;
        else if (w_cfg_next[4]) w_colour = 12'hF00;
        else if (w_cfg_next[3]) w_colour = 12'h0FF;
        else if (w_cfg_next[2]) w_colour = 12'h952;
        else if (w_cfg_next[1]) w_colour = 12'h00F;
    end

    assign w_video_on = (w_hcount_next < H_VIS) && (w_vcount_next < V_VIS);

    // Outputs are registered from next-state values so they line up with the counters.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            r_div         <= '0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_cfg         <= 8'h00;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb         <= 12'h000;
            r_pixel_tick  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_next;
            r_hcount      <= w_hcount_next;
            r_vcount      <= w_vcount_next;
            r_cfg         <= w_cfg_next;
            r_hsync       <= !((w_hcount_next >= H_SYNC_S) && (w_hcount_next <= H_SYNC_E));
            r_vsync       <= !((w_vcount_next >= V_SYNC_S) && (w_vcount_next <= V_SYNC_E));
            r_rgb         <= w_video_on ? w_colour : 12'h000;
            r_pixel_tick  <= (w_div_next == DIV_LAST);
            r_frame_start <= w_frame_end;
        end
    end

    assign Hsync       = r_hsync;
    assign Vsync       = r_vsync;
    assign vgaRed      = r_rgb[11:8];
    assign vgaGreen    = r_rgb[7:4];
    assign vgaBlue     = r_rgb[3:0];
    assign pixel_tick  = r_pixel_tick;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Directed bench for vga_timing_sequencer. Horizontal timing and divider are the
// real 640x480 values; the frame is shortened to 6 lines so several frames fit in the run.
module tb_vga_timing_sequencer;

    localparam int V_VIS   = 2;
    localparam int V_SS    = 3;
    localparam int V_SE    = 4;
    localparam int V_TOT   = 6;
    localparam int LINE_CK = 800 * 4;
    localparam int FRAME_CK = LINE_CK * V_TOT;

    logic       clk_100Mhz = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic       Hsync, Vsync, pixel_tick, frame_start;
    logic [3:0] vgaRed, vgaGreen, vgaBlue;
    logic [9:0] hcount, vcount;
    logic [11:0] w_rgb;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fs_cnt = 0;
    int t_fs_prev = 0;
    int t_fs = 0;

    int h_pts [7]  = '{639, 640, 658, 659, 755, 756, 799};
    int h_sync [7] = '{1, 1, 1, 0, 0, 1, 1};
    int v_sync [5] = '{1, 1, 0, 0, 1};

    vga_timing_sequencer #(
        .CLK_DIV(4), .H_VISIBLE(640), .H_SYNC_START(659), .H_SYNC_END(755), .H_TOTAL(800),
        .V_VISIBLE(V_VIS), .V_SYNC_START(V_SS), .V_SYNC_END(V_SE), .V_TOTAL(V_TOT)
    ) dut (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .sw         (sw),
        .Hsync      (Hsync),
        .Vsync      (Vsync),
        .vgaRed     (vgaRed),
        .vgaGreen   (vgaGreen),
        .vgaBlue    (vgaBlue),
        .pixel_tick (pixel_tick),
        .hcount     (hcount),
        .vcount     (vcount),
        .frame_start(frame_start)
    );

    assign w_rgb = {vgaRed, vgaGreen, vgaBlue};

    always #5 clk_100Mhz = ~clk_100Mhz;

    always @(posedge clk_100Mhz) begin
        cyc <= cyc + 1;
        if (frame_start) fs_cnt <= fs_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance on falling edges until the counters show (h, v); a timeout counts as a failure.
    task automatic wait_pos(input int h, input int v, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk_100Mhz);
            if (hcount == 10'(h) && vcount == 10'(v)) return;
        end
        total++;
        bad++;
        $error("FAIL wait_pos_%0d_%0d: observed=timeout expected=reached", h, v);
    endtask

    // Walk up to the frame wrap edge, optionally changing sw in the last cycle before it,
    // then check the first cycle of the new frame.
    task automatic frame_wrap(input logic change_sw, input logic [7:0] new_sw,
                              input logic [11:0] exp_rgb, input string tag);
        wait_pos(799, V_TOT - 1, FRAME_CK + 100);
        repeat (3) @(negedge clk_100Mhz);
        check({tag, "_tick_before_wrap"}, pixel_tick, 1);
        check({tag, "_no_fs_before_wrap"}, frame_start, 0);
        if (change_sw) sw = new_sw;
        @(negedge clk_100Mhz);
        check({tag, "_fs"}, frame_start, 1);
        check({tag, "_h0"}, hcount, 0);
        check({tag, "_v0"}, vcount, 0);
        check({tag, "_rgb00"}, w_rgb, exp_rgb);
        t_fs_prev = t_fs;
        t_fs = cyc;
        @(negedge clk_100Mhz);
        check({tag, "_fs_one_cycle"}, frame_start, 0);
    endtask

    initial begin
        reset = 1'b1;
        sw    = 8'h02;
        repeat (3) @(posedge clk_100Mhz);
        @(negedge clk_100Mhz);
        check("rst_hcount", hcount, 0);
        check("rst_vcount", vcount, 0);
        check("rst_hsync", Hsync, 1);
        check("rst_vsync", Vsync, 1);
        check("rst_rgb", w_rgb, 12'h000);
        check("rst_tick", pixel_tick, 0);
        check("rst_fs", frame_start, 0);

        @(posedge clk_100Mhz);
        #1 reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_100Mhz);
            check($sformatf("tick_cycle%0d", i), pixel_tick, (i % 4 == 0) ? 1 : 0);
            if (i == 1) begin
                check("hsync_h0", Hsync, 1);
                check("vsync_v0", Vsync, 1);
            end
        end

        // Line 0 of the first frame: cfg is still 0, so visible pixels are black.
        for (int k = 0; k < 7; k++) begin
            wait_pos(h_pts[k], 0, LINE_CK + 100);
            check($sformatf("hsync_h%0d", h_pts[k]), Hsync, h_sync[k]);
            if (k == 0) check("frame0_black", w_rgb, 12'h000);
        end
        repeat (4) @(negedge clk_100Mhz);
        check("hwrap_h", hcount, 0);
        check("hwrap_v", vcount, 1);

        for (int v = 1; v < V_TOT; v++) begin
            wait_pos(0, v, LINE_CK + 100);
            check($sformatf("vsync_v%0d", v), Vsync, v_sync[v-1]);
        end
        check("fs_none_frame0", fs_cnt, 0);

        // First wrap latches sw=02: blue.
        frame_wrap(1'b0, 8'h00, 12'h00F, "wrap1");
        wait_pos(639, 0, LINE_CK + 100);
        check("blue_h639", w_rgb, 12'h00F);
        check("fs_count1", fs_cnt, 1);
        wait_pos(640, 0, 100);
        check("blank_h640", w_rgb, 12'h000);
        wait_pos(100, 1, LINE_CK + 100);
        sw = 8'h10;
        wait_pos(639, 1, LINE_CK + 100);
        check("blue_after_sw_change", w_rgb, 12'h00F);
        wait_pos(0, V_VIS, LINE_CK + 100);
        check("blank_vvis", w_rgb, 12'h000);

        // Second wrap: red from pixel (0,0), one frame after the first pulse.
        frame_wrap(1'b0, 8'h00, 12'hF00, "wrap2");
        check("frame_period", t_fs - t_fs_prev, FRAME_CK);
        wait_pos(639, 1, LINE_CK * 2 + 100);
        check("red_h639_v1", w_rgb, 12'hF00);
        check("fs_count2", fs_cnt, 2);

        // sw changes in the cycle ending with the wrap edge; 86 decodes to white.
        frame_wrap(1'b1, 8'h86, 12'hFFF, "wrap3");
        wait_pos(320, 1, LINE_CK * 2 + 100);
        check("white_h320_v1", w_rgb, 12'hFFF);

        // Mid-frame reset inside both sync pulses.
        wait_pos(700, 4, LINE_CK * 4 + 100);
        check("pre_rst_hsync", Hsync, 0);
        check("pre_rst_vsync", Vsync, 0);
        reset = 1'b1;
        @(posedge clk_100Mhz);
        #1 reset = 1'b0;
        @(negedge clk_100Mhz);
        check("mrst_hcount", hcount, 0);
        check("mrst_vcount", vcount, 0);
        check("mrst_hsync", Hsync, 1);
        check("mrst_vsync", Vsync, 1);
        check("mrst_rgb", w_rgb, 12'h000);
        check("mrst_fs", frame_start, 0);
        check("mrst_tick_c1", pixel_tick, 0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk_100Mhz);
            check($sformatf("mrst_tick_c%0d", i), pixel_tick, (i == 4) ? 1 : 0);
        end
        wait_pos(10, 0, 200);
        check("mrst_cfg_cleared", w_rgb, 12'h000);
        check("fs_count3", fs_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_sequencer.md
Name: vga_timing_sequencer

Overview:
Sequences the 640x480 VGA output path from the 100 MHz board clock. It generates the pixel-rate enable, horizontal and vertical counters, active-low sync pulses and blanking. It also drives the 4-bit RGB outputs from a switch-selected colour. The switch value is latched only at frame boundaries so the displayed colour never changes mid-frame.

Parameters:
CLK_DIV, 4, board clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); legal values are 2 or greater.
H_VISIBLE, 640, visible pixels per line (hcount 0..639).
H_SYNC_START, 659, first hcount with Hsync low.
H_SYNC_END, 755, last hcount with Hsync low.
H_TOTAL, 800, pixels per line (hcount 0..799).
V_VISIBLE, 480, visible lines (vcount 0..479).
V_SYNC_START, 493, first vcount with Vsync low.
V_SYNC_END, 494, last vcount with Vsync low.
V_TOTAL, 525, lines per frame (vcount 0..524).

Ports:
clk_100Mhz  in  1  board clock; the only clock.
reset  in  1  synchronous, active-high reset.
sw  in  8  colour-select switches.
Hsync  out  1  horizontal sync, active low.
Vsync  out  1  vertical sync, active low.
vgaRed  out  4  red intensity.
vgaGreen  out  4  green intensity.
vgaBlue  out  4  blue intensity.
pixel_tick  out  1  one-clock pulse once every CLK_DIV clocks; it marks a pixel advance.
hcount  out  10  current pixel column.
vcount  out  10  current line.
frame_start  out  1  one-clock pulse in the first cycle of each frame.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and sampled on the rising edge of clk_100Mhz. Asserting reset at any point, including mid-line or mid-frame, forces the reset state on the next edge.
- Reset state: div=0, hcount=0, vcount=0, cfg=8'h00, Hsync=1, Vsync=1, RGB=0, pixel_tick=0, frame_start=0.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pixel_tick=1 exactly in the cycles where div==CLK_DIV-1.
  - After reset deasserts, the first pixel_tick occurs in the CLK_DIV-th cycle.
- Counters:
  - Counters change only on the edge that ends a pixel_tick cycle.
  - hcount increments on each tick. At H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps from V_TOTAL-1 to 0 together with the hcount wrap.
  - Counters never exceed TOTAL-1.
  - Line length = H_TOTAL*CLK_DIV = 3200 clocks. Frame length = 1,680,000 clocks.
- Invariant: every output is registered. Each output is computed from the next-state counters and cfg, so in every cycle it corresponds to the hcount/vcount values presented in that same cycle. There is no pipeline offset between counters and video.
- Sync:
  - Hsync=0 iff H_SYNC_START <= hcount <= H_SYNC_END.
  - Vsync=0 iff V_SYNC_START <= vcount <= V_SYNC_END.
  - Vsync depends only on vcount, not on hcount.
- Blanking: video_on = (hcount < H_VISIBLE) && (vcount < V_VISIBLE). When video_on=0, RGB=0.
- Configuration latch:
  - cfg <= sw on the same edge that moves the counters to (0,0), i.e. the frame wrap edge. This edge does not occur out of reset.
  - frame_start=1 in the cycle immediately following that edge, and only then.
  - Changes on sw at any other time have no visible effect until the next frame wrap.
- Colour decode of cfg, highest set bit wins, output as {R,G,B}:
  - bit7 FFF white
  - bit6 FF0 yellow
  - bit5 F0F magenta
  - bit4 F00 red
  - bit3 0FF cyan
  - bit2 952 brown
  - bit1 00F blue
  - bit0 or none: 000 black
- Boundaries:
  - hcount=639 is visible; hcount=640 is blanked.
  - vcount=479 is visible; vcount=480 is blanked.
  - The 799->0 hcount wrap and the 524->0 vcount wrap occur on the same edge at end of frame.
  - sw changing in the same cycle as the frame-wrap edge: the value sampled on that edge is used.

Test Plan:
- Reset then run 3200 clocks -> pixel_tick period is exactly 4 clocks. Hsync is high at hcount 0, 639, 640 and 658, low at hcount 659 and 755, and high again at 756 and 799. hcount wraps 799->0 and vcount goes 0->1.
- Run one full frame -> Vsync is high at vcount 0, 479, 480 and 492, low at vcount 493 and 494, and high at 495 and 524. frame_start pulses exactly once, 1,680,000 clocks after the previous pulse.
- sw=8'h02 held from reset -> the first frame is black (cfg=0). After the first frame_start, RGB=0,0,F for every visible pixel and 0 for hcount>=640 or vcount>=480.
- Change sw from 8'h02 to 8'h10 at vcount=200 -> RGB stays 0,0,F until the frame wrap, then becomes F,0,0 from pixel (0,0).
- Set sw=8'h86 before a frame wrap -> the following frame outputs white F,F,F, confirming highest-set-bit priority.
- Assert reset for one cycle at hcount=400, vcount=300 -> the next cycle shows counters 0/0, syncs high, RGB 0 and cfg 0. The first pixel_tick after reset appears in the 4th cycle after reset deasserts.
